// File: rtl/mcl_arb.sv
// mcl_arb: round-robin EBOX memory-control arbiter/sequencer.
// Optional WAIT timeout abort: define MCL_ARB_TIMEOUT_EN.
module mcl_arb #(
  parameter int NCH       = 4,
  parameter int RETRY_MAX = 7,
  parameter int TIMEOUT   = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] reqValid,
  input  logic [NCH-1:0] reqPublic,
  input  logic [NCH-1:0] reqIot,
  input  logic           cshEBOXT0,
  input  logic           cshEBOXRetry,
  input  logic           mboxRespIn,
  input  logic           pfEBOXHandle,
  input  logic           pfRelease,
  output logic [NCH-1:0] grant,
  output logic           eboxReqIn,
  output logic           mboxXfer,
  output logic           pfHold,
  output logic           ptPublic,
  output logic [NCH-1:0] done,
  output logic [NCH-1:0] pageFail,
  output logic [NCH-1:0] abort,
  output logic           busy
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RETRY,
    S_PFHOLD
  } state_t;

  state_t             r_state;
  logic [PW-1:0]      r_rrPtr;
  logic [3:0]         r_retryCnt;

  logic [2*NCH-1:0]   w_dbl;
  logic [PW-1:0]      w_off;
  logic [PW:0]        w_sum;
  logic [PW-1:0]      w_pick;
  logic [PW-1:0]      w_nextPtr;
  logic [3:0]         w_retryInc;

`ifdef MCL_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]      r_waitCnt;
`else
  logic               w_unusedTimeout;
  assign w_unusedTimeout = |TIMEOUT;
`endif

  // Rotate requests so bit 0 is the channel at rrPtr.
  assign w_dbl = {reqValid, reqValid} >> r_rrPtr;

  // Offset of the first pending channel at/after rrPtr.
  always_comb begin
    w_off = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_dbl[i]) w_off = PW'(i);
    end
  end

  assign w_sum = {1'b0, r_rrPtr} + {1'b0, w_off};
  assign w_pick = (w_sum >= (PW+1)'(NCH))
                ? PW'(w_sum - (PW+1)'(NCH))
                : w_sum[PW-1:0];
  assign w_nextPtr = (w_pick == PW'(NCH - 1))
                   ? '0
                   : w_pick + 1'b1;
  assign w_retryInc = r_retryCnt + 4'd1;

  // Transfer sequencer; every output is a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rrPtr    <= '0;
      r_retryCnt <= '0;
      grant      <= '0;
      eboxReqIn  <= 1'b0;
      mboxXfer   <= 1'b0;
      pfHold     <= 1'b0;
      ptPublic   <= 1'b0;
      done       <= '0;
      pageFail   <= '0;
      abort      <= '0;
      busy       <= 1'b0;
`ifdef MCL_ARB_TIMEOUT_EN
      r_waitCnt  <= '0;
`endif
    end else begin
      mboxXfer <= 1'b0;
      done     <= '0;
      pageFail <= '0;
      abort    <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (|reqValid) begin
            r_state    <= S_REQ;
            grant      <= NCH'(1) << w_pick;
            r_rrPtr    <= w_nextPtr;
            ptPublic   <= reqPublic[w_pick] &
                          ~reqIot[w_pick];
            r_retryCnt <= '0;
            eboxReqIn  <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_REQ: begin
          if (cshEBOXRetry) begin
            r_state   <= S_RETRY;
            eboxReqIn <= 1'b0;
          end else if (cshEBOXT0) begin
            eboxReqIn <= 1'b0;
            if (mboxRespIn) begin
              r_state  <= S_IDLE;
              mboxXfer <= 1'b1;
              done     <= grant;
              grant    <= '0;
              busy     <= 1'b0;
            end else begin
              r_state <= S_WAIT;
`ifdef MCL_ARB_TIMEOUT_EN
              r_waitCnt <= '0;
`endif
            end
          end
        end
        S_RETRY: begin
          r_retryCnt <= w_retryInc;
          if (w_retryInc == 4'(RETRY_MAX)) begin
            r_state <= S_IDLE;
            abort   <= grant;
            grant   <= '0;
            busy    <= 1'b0;
          end else begin
            r_state   <= S_REQ;
            eboxReqIn <= 1'b1;
          end
        end
        S_WAIT: begin
          if (pfEBOXHandle) begin
            r_state  <= S_PFHOLD;
            pageFail <= grant;
            pfHold   <= 1'b1;
          end else if (mboxRespIn) begin
            r_state  <= S_IDLE;
            mboxXfer <= 1'b1;
            done     <= grant;
            grant    <= '0;
            busy     <= 1'b0;
          end
`ifdef MCL_ARB_TIMEOUT_EN
          else if (r_waitCnt == TW'(TIMEOUT - 1)) begin
            r_state <= S_IDLE;
            abort   <= grant;
            grant   <= '0;
            busy    <= 1'b0;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
`endif
        end
        S_PFHOLD: begin
          if (pfRelease) begin
            r_state <= S_IDLE;
            pfHold  <= 1'b0;
            grant   <= '0;
            busy    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcl_arb.sv
// tb_mcl_arb: random + directed bench for mcl_arb
// against a transaction-level reference model.
module tb_mcl_arb;
  localparam int NCH       = 4;
  localparam int RETRY_MAX = 7;
  localparam int TIMEOUT   = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] reqValid, reqPublic, reqIot;
  logic           cshEBOXT0, cshEBOXRetry, mboxRespIn;
  logic           pfEBOXHandle, pfRelease;
  logic [NCH-1:0] grant, done, pageFail, abort;
  logic           eboxReqIn, mboxXfer, pfHold;
  logic           ptPublic, busy;

  mcl_arb #(
    .NCH(NCH), .RETRY_MAX(RETRY_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqPublic(reqPublic),
    .reqIot(reqIot), .cshEBOXT0(cshEBOXT0),
    .cshEBOXRetry(cshEBOXRetry), .mboxRespIn(mboxRespIn),
    .pfEBOXHandle(pfEBOXHandle), .pfRelease(pfRelease),
    .grant(grant), .eboxReqIn(eboxReqIn),
    .mboxXfer(mboxXfer), .pfHold(pfHold),
    .ptPublic(ptPublic), .done(done),
    .pageFail(pageFail), .abort(abort), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  // reference model: owner index (-1 = idle) plus phase flags
  int m_owner, m_ptr, m_retries, m_wait;
  bit m_retrying, m_accepted, m_held, m_pub;
  logic [NCH-1:0] e_done, e_pf, e_abort;
  bit e_xfer;

  function automatic void model_reset();
    m_owner = -1; m_ptr = 0; m_retries = 0; m_wait = 0;
    m_retrying = 0; m_accepted = 0; m_held = 0; m_pub = 0;
    e_done = '0; e_pf = '0; e_abort = '0; e_xfer = 0;
  endfunction

  function automatic void finish_ok();
    e_done[m_owner] = 1'b1;
    e_xfer = 1'b1;
    m_owner = -1;
  endfunction

  function automatic void model_step();
    e_done = '0; e_pf = '0; e_abort = '0; e_xfer = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (m_ptr + k) % NCH;
        if (m_owner < 0 && reqValid[c]) m_owner = c;
      end
      if (m_owner >= 0) begin
        m_ptr = (m_owner + 1) % NCH;
        m_pub = reqPublic[m_owner] && !reqIot[m_owner];
        m_retries = 0; m_retrying = 0;
        m_accepted = 0; m_held = 0;
      end
    end else if (m_held) begin
      if (pfRelease) begin
        m_owner = -1; m_held = 0;
      end
    end else if (m_retrying) begin
      m_retrying = 0;
      m_retries++;
      if (m_retries == RETRY_MAX) begin
        e_abort[m_owner] = 1'b1;
        m_owner = -1;
      end
    end else if (m_accepted) begin
      if (pfEBOXHandle) begin
        e_pf[m_owner] = 1'b1;
        m_held = 1;
      end else if (mboxRespIn) begin
        finish_ok();
      end
`ifdef MCL_ARB_TIMEOUT_EN
      else begin
        m_wait++;
        if (m_wait == TIMEOUT) begin
          e_abort[m_owner] = 1'b1;
          m_owner = -1;
        end
      end
`endif
    end else begin
      if (cshEBOXRetry) m_retrying = 1;
      else if (cshEBOXT0) begin
        if (mboxRespIn) finish_ok();
        else begin
          m_accepted = 1; m_wait = 0;
        end
      end
    end
  endfunction

  function automatic logic [NCH-1:0] onehot(int o);
    if (o < 0) return '0;
    return NCH'(1) << o;
  endfunction

  task automatic cmp(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, act, exp);
    end
  endtask

  // compare every DUT output to the model away from the edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_grant", grant, onehot(m_owner));
      cmp("m_busy", busy, m_owner >= 0);
      cmp("m_req", eboxReqIn,
          m_owner >= 0 && !m_accepted && !m_retrying);
      cmp("m_hold", pfHold, m_owner >= 0 && m_held);
      cmp("m_xfer", mboxXfer, e_xfer);
      cmp("m_done", done, e_done);
      cmp("m_pf", pageFail, e_pf);
      cmp("m_abort", abort, e_abort);
      if (m_owner >= 0) cmp("m_pub", ptPublic, m_pub);
    end
  end

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic clr_resp();
    cshEBOXT0 = 0; cshEBOXRetry = 0; mboxRespIn = 0;
    pfEBOXHandle = 0; pfRelease = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [NCH-1:0] seq [4];
    seq[0] = 4'b0001; seq[1] = 4'b0100;
    seq[2] = 4'b0001; seq[3] = 4'b0100;
    reset = 1; reqValid = '0; reqPublic = '0; reqIot = '0;
    clr_resp();
    model_reset();
    tick(); tick();
    reset = 0;
    chk_en = 1;
    cmp("rst_grant", grant, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_req", eboxReqIn, 0);
    cmp("rst_pulses", {done, pageFail, abort, mboxXfer}, 0);

    // round robin between ch0 and ch2, T0+resp same cycle
    reqValid = 4'b0101; reqPublic = 4'b0001;
    cshEBOXT0 = 1; mboxRespIn = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      cmp("rr_grant", grant, seq[i]);
      tick();
      cmp("rr_done", done, seq[i]);
    end
    reqValid = '0; clr_resp();
    tick();

    // ch1: T0 cycle 2, resp cycle 5, done cycle 6
    reqValid = 4'b0010;
    tick();
    cmp("c_grant", grant, 4'b0010);
    cmp("c_req", eboxReqIn, 1);
    cshEBOXT0 = 1;
    tick();
    cshEBOXT0 = 0;
    cmp("c_wait_req", eboxReqIn, 0);
    tick(); tick();
    mboxRespIn = 1;
    tick();
    mboxRespIn = 0; reqValid = '0;
    cmp("c_done", done, 4'b0010);
    cmp("c_xfer", mboxXfer, 1);
    cmp("c_busy", busy, 0);
    tick();
    cmp("c_done_pulse", done, 0);
    cmp("c_xfer_pulse", mboxXfer, 0);

    // ch3: retry exhaust, retry wins over T0
    reqValid = 4'b1000;
    tick();
    cmp("d_grant", grant, 4'b1000);
    for (int r = 1; r <= RETRY_MAX; r++) begin
      cshEBOXRetry = 1; cshEBOXT0 = 1;
      tick();
      cmp("d_req_off", eboxReqIn, 0);
      cshEBOXRetry = 0; cshEBOXT0 = 0;
      tick();
      if (r < RETRY_MAX) cmp("d_req_back", eboxReqIn, 1);
      else begin
        cmp("d_abort", abort, 4'b1000);
        cmp("d_nodone", done, 0);
        cmp("d_busy", busy, 0);
      end
    end
    reqValid = '0;
    tick();
    cmp("d_abort_pulse", abort, 0);

    // ch0: page fail wins over resp, hold until release
    reqValid = 4'b0001;
    tick();
    cshEBOXT0 = 1;
    tick();
    cshEBOXT0 = 0; pfEBOXHandle = 1; mboxRespIn = 1;
    tick();
    cmp("e_pf", pageFail, 4'b0001);
    cmp("e_hold", pfHold, 1);
    cmp("e_nodone", done, 0);
    cmp("e_noxfer", mboxXfer, 0);
    reqValid = '0; pfEBOXHandle = 0;
    tick();
    cmp("e_hold2", pfHold, 1);
    cmp("e_resp_ign", done, 0);
    cmp("e_pf_pulse", pageFail, 0);
    mboxRespIn = 0; pfRelease = 1;
    tick();
    pfRelease = 0;
    cmp("e_release", pfHold, 0);
    cmp("e_busy", busy, 0);

    // reset in WAIT clears state and rrPtr
    reqValid = 4'b0100;
    tick();
    cmp("f_grant", grant, 4'b0100);
    cshEBOXT0 = 1;
    tick();
    cshEBOXT0 = 0; reqValid = '0;
    reset = 1; model_reset();
    #1;
    cmp("f_rst_grant", grant, 0);
    cmp("f_rst_busy", busy, 0);
    tick();
    reset = 0;
    reqValid = 4'b1010;
    tick();
    cmp("f_ptr0_grant", grant, 4'b0010);
    cshEBOXT0 = 1; mboxRespIn = 1;
    tick();
    cmp("f_done", done, 4'b0010);
    reqValid = '0; clr_resp();
    tick();

`ifdef MCL_ARB_TIMEOUT_EN
    reqValid = 4'b0001;
    tick();
    cshEBOXT0 = 1;
    tick();
    cshEBOXT0 = 0;
    for (int w = 1; w <= TIMEOUT; w++) begin
      tick();
      if (w < TIMEOUT) cmp("t_no_abort", abort, 0);
      else cmp("t_abort", abort, 4'b0001);
    end
    reqValid = '0;
    tick();
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cshEBOXT0    = ($urandom_range(0, 2) == 0);
      cshEBOXRetry = ($urandom_range(0, 2) == 0);
      mboxRespIn   = ($urandom_range(0, 2) == 0);
      pfEBOXHandle = ($urandom_range(0, 7) == 0);
      pfRelease    = ($urandom_range(0, 3) == 0);
      tick();
      for (int c = 0; c < NCH; c++) begin
        if (e_done[c] | e_pf[c] | e_abort[c])
          reqValid[c] = 1'b0;
        else if (!reqValid[c] &&
                 $urandom_range(0, 3) == 0) begin
          reqValid[c]  = 1'b1;
          reqPublic[c] = 1'($urandom_range(0, 1));
          reqIot[c]    = 1'($urandom_range(0, 1));
        end else if (reqValid[c] &&
                     $urandom_range(0, 60) == 0)
          reqValid[c] = 1'b0;
      end
    end

    // drain
    reqValid = '0;
    for (int n = 0; n < 200; n++) begin
      cshEBOXT0    = ($urandom_range(0, 1) == 0);
      cshEBOXRetry = 0;
      mboxRespIn   = ($urandom_range(0, 1) == 0);
      pfEBOXHandle = 0;
      pfRelease    = ($urandom_range(0, 1) == 0);
      tick();
    end
    cmp("drain_idle", busy, 0);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
